// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises one 8*NBYTES-bit word as NBYTES back-to-back UART bytes.
// The most significant byte goes first, and each byte is sent LSB first.
// Default build: 8N1 frames, 10 bits per byte.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (11 bits per byte).
// ready is high only in IDLE. A load is accepted when rdy is high in that cycle.
// frame_done marks the last cycle of the final stop bit of a word.
module uart_word_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NBYTES       = 3
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic [8*NBYTES-1:0]   data_in,
   input  logic                  rdy,
   output logic                  ready,
   output logic                  tx,
   output logic                  frame_done
);

   localparam int W      = 8 * NBYTES;
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
   logic [W-1:0]        word_q, word_d;

   logic [7:0]          cur_byte;
   logic                bit_end;

   // The byte on the wire is always the top byte; the word shifts left between bytes.
   assign cur_byte = word_q[W-1 -: 8];
   assign bit_end  = (cnt_q == CNT_LAST);

   // State register: async active-low reset aborts any frame in flight
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
      end
   end

   // Next-state logic: baud counter restarts on every state change, no gap between bytes
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rdy) begin
               state_d    = S_START;
               word_d     = data_in;
               bit_idx_d  = '0;
               byte_idx_d = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               cnt_d     = '0;
               bit_idx_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = S_PARITY;
`else
                  state_d   = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (byte_idx_q == BYTE_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  state_d    = S_START;
                  byte_idx_d = byte_idx_q + 1'b1;
                  word_d     = word_q << 8;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode: line level, ready and end-of-word pulse from the current state
   always_comb begin
      ready      = 1'b0;
      tx         = 1'b1;
      frame_done = 1'b0;
      case (state_q)
         S_IDLE:   ready = 1'b1;
         S_START:  tx    = 1'b0;
         S_DATA:   tx    = cur_byte[bit_idx_q];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx    = ^cur_byte;
`endif
         S_STOP:   frame_done = bit_end && (byte_idx_q == BYTE_LAST);
         default:  tx    = 1'b1;
      endcase
   end

endmodule
